game_frame_tx: RTL and testbench

- Transmit-side counterpart of the UART game-state path. Each frame tick, it snapshots the local game state: own pad y, ball x/y, and the host flag.
- It serializes the snapshot into a fixed 6-byte frame with a sync byte and an XOR checksum.
- Bytes are delivered over a valid/ready byte interface to the UART transmitter (FIFO write side).
- The remote board's frame receiver decodes these frames into its *_uart position inputs.

---
 rtl/game_frame_tx_pkg.sv | 53 +++++
 rtl/game_frame_tx_tick_div.sv | 38 +++
 rtl/game_frame_tx.sv | 117 +++++++++++
 tb/tb_game_frame_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_frame_tx_pkg.sv
// Shared definitions for the UART game-state frame: byte layout, field splits,
// FSM encoding and the packer/checksum helpers used by both frame ends.
package game_frame_tx_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_BYTES       = 6;
  localparam logic [2:0]  LAST_IDX          = 3'(FRAME_BYTES - 1);
  localparam int unsigned TICK_CNT_W        = 8;

  localparam int unsigned Y_PAD_W  = 10;
  localparam int unsigned X_BALL_W = 11;
  localparam int unsigned Y_BALL_W = 10;

  // Upper bits of each field that land in the earlier byte of a split pair.
  localparam int unsigned Y_PAD_HI_BITS  = 8;
  localparam int unsigned X_BALL_HI_BITS = 6;
  localparam int unsigned Y_BALL_HI_BITS = 3;

  typedef logic [7:0] byte_t;
  typedef byte_t [FRAME_BYTES-1:0] frame_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } frame_state_e;

  function automatic byte_t frame_checksum(input frame_t f);
    return f[1] ^ f[2] ^ f[3] ^ f[4];
  endfunction

  function automatic frame_t pack_frame(
    input byte_t               sync,
    input logic                host,
    input logic [Y_PAD_W-1:0]  y_pad,
    input logic [X_BALL_W-1:0] x_ball,
    input logic [Y_BALL_W-1:0] y_ball
  );
    logic [X_BALL_W-1:0] x;
    logic [Y_BALL_W-1:0] y;
    frame_t              f;
    x    = host ? x_ball : {X_BALL_W{1'b0}};
    y    = host ? y_ball : {Y_BALL_W{1'b0}};
    f[0] = sync;
    f[1] = y_pad[Y_PAD_W-1 -: Y_PAD_HI_BITS];
    f[2] = {y_pad[Y_PAD_W-Y_PAD_HI_BITS-1:0], x[X_BALL_W-1 -: X_BALL_HI_BITS]};
    f[3] = {x[X_BALL_W-X_BALL_HI_BITS-1:0], y[Y_BALL_W-1 -: Y_BALL_HI_BITS]};
    f[4] = {y[Y_BALL_W-Y_BALL_HI_BITS-1:0], host};
    f[5] = frame_checksum(f);
    return f;
  endfunction

endpackage

// File: rtl/game_frame_tx_tick_div.sv
// Frame-tick divider: counts frame_tick pulses and flags every TICK_DIV-th one
// as due in the same cycle.
module game_frame_tx_tick_div
  import game_frame_tx_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  output logic due
);

  logic [TICK_CNT_W-1:0] cnt_r;
  logic                  at_end_s;

  // due decode from the current count
  always_comb begin
    at_end_s = (cnt_r == TICK_CNT_W'(TICK_DIV - 1));
    due      = frame_tick && at_end_s;
  end

  // tick counter, wraps on the due tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {TICK_CNT_W{1'b0}};
    end else if (frame_tick) begin
      if (at_end_s) begin
        cnt_r <= {TICK_CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + TICK_CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/game_frame_tx.sv
// Game-state frame transmitter: snapshots pad/ball/host on a due frame tick and
// streams a 6-byte sync+payload+checksum frame over a valid/ready byte port.
module game_frame_tx
  import game_frame_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                host,
  input  logic [Y_PAD_W-1:0]  y_pad,
  input  logic [X_BALL_W-1:0] x_ball,
  input  logic [Y_BALL_W-1:0] y_ball,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                busy,
  output logic                frame_dropped
);

  frame_state_e state_r, state_s;
  logic [2:0]   idx_r, idx_s, idx_inc_s;
  frame_t       frame_r, frame_s;
  logic [7:0]   tx_data_r, tx_data_s;
  logic         tx_valid_r, tx_valid_s;
  logic         busy_r, busy_s;
  logic         drop_r, drop_s;
  logic         due_s;
  logic         hs_s;

  game_frame_tx_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .due        (due_s)
  );

  // next-state, next-byte and status decode
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    frame_s    = frame_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = 1'b0;
    hs_s       = tx_valid_r && tx_ready;
    idx_inc_s  = idx_r + 3'd1;
    // Any due tick outside IDLE is lost, including one on the final handshake.
    drop_s     = due_s && (state_r != ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        if (due_s) begin
          frame_s    = pack_frame(SYNC_BYTE, host, y_pad, x_ball, y_ball);
          idx_s      = 3'd0;
          tx_data_s  = frame_s[0];
          tx_valid_s = 1'b1;
          state_s    = ST_SEND;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SEND: begin
        tx_valid_s = 1'b1;
        if (hs_s) begin
          if (idx_r == LAST_IDX) begin
            tx_valid_s = 1'b0;
            state_s    = ST_DONE;
          end else begin
            idx_s      = idx_inc_s;
            tx_data_s  = frame_r[idx_inc_s];
          end
        end else begin
          state_s    = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // state, snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      frame_r    <= {(FRAME_BYTES*8){1'b0}};
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      frame_r    <= frame_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      drop_r     <= drop_s;
    end
  end

  assign tx_data       = tx_data_r;
  assign tx_valid      = tx_valid_r;
  assign busy          = busy_r;
  assign frame_dropped = drop_r;

endmodule

// File: tb/tb_game_frame_tx.sv
// Randomized bench for game_frame_tx: a byte-queue frame model predicts every
// transfer, drop and busy state; a TICK_DIV=3 instance covers the divider.
module tb_game_frame_tx;

  localparam int DIV = 1;

  logic        clk = 1'b0;
  logic        rst, frame_tick, host, tx_ready;
  logic [9:0]  y_pad, y_ball;
  logic [10:0] x_ball;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, frame_dropped;

  logic        tick3, ready3;
  logic [7:0]  data3;
  logic        valid3, busy3, drop3;

  always #5 clk = ~clk;

  game_frame_tx #(.SYNC_BYTE(8'hA5), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .host(host),
    .y_pad(y_pad), .x_ball(x_ball), .y_ball(y_ball), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .frame_dropped(frame_dropped)
  );

  game_frame_tx #(.SYNC_BYTE(8'hA5), .TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .frame_tick(tick3), .host(host),
    .y_pad(y_pad), .x_ball(x_ball), .y_ball(y_ball), .tx_ready(ready3),
    .tx_data(data3), .tx_valid(valid3), .busy(busy3), .frame_dropped(drop3)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] exp6[6];
  bit  done_pend = 1'b0;
  bit  drop_pend = 1'b0;
  bit  rst_prev  = 1'b1;
  bit  prev_wait = 1'b0;
  logic [7:0] prev_data = 8'd0;
  int  tick_num  = 0;
  int  obs_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame model from the byte-layout rules, plain integer arithmetic.
  function automatic void push_frame(input bit h, input int yp, input int xb, input int yb);
    int xe, ye, b1, b2, b3, b4;
    xe = h ? xb : 0;
    ye = h ? yb : 0;
    b1 = yp / 4;
    b2 = (yp % 4) * 64 + xe / 32;
    b3 = (xe % 32) * 8 + ye / 128;
    b4 = (ye % 128) * 2 + (h ? 1 : 0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(b1));
    exp_q.push_back(8'(b2));
    exp_q.push_back(8'(b3));
    exp_q.push_back(8'(b4));
    exp_q.push_back(8'(b1 ^ b2 ^ b3 ^ b4));
  endfunction

  // One cycle: check outputs against the model, then drive the next inputs.
  task automatic step(input bit tk, input bit rdy, input bit rs,
                      input bit h, input int yp, input int xb, input int yb);
    bit mbusy;
    bit due;
    @(negedge clk);
    mbusy = (exp_q.size() != 0) || done_pend;
    if (rst_prev) begin
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drop", {31'd0, frame_dropped}, 32'd0);
    end else begin
      chk("valid", {31'd0, tx_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("data", {24'd0, tx_data}, {24'd0, exp_q[0]});
      chk("busy", {31'd0, busy}, {31'd0, mbusy});
      chk("dropped", {31'd0, frame_dropped}, {31'd0, drop_pend});
      if (prev_wait) chk("stable", {24'd0, tx_data}, {24'd0, prev_data});
    end
    if (frame_dropped) obs_drops++;
    done_pend = 1'b0;
    drop_pend = 1'b0;
    rst = rs; frame_tick = tk; tx_ready = rdy; host = h;
    y_pad = 10'(yp); x_ball = 11'(xb); y_ball = 10'(yb);
    prev_wait = tx_valid && !rdy && !rs;
    prev_data = tx_data;
    if (rs) begin
      exp_q.delete();
      tick_num = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (exp_q.size() != 0 && rdy) begin
        cap_q.push_back(tx_data);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_pend = 1'b1;
      end
      if (tk) begin
        due = (tick_num % DIV) == (DIV - 1);
        tick_num++;
        if (due) begin
          if (mbusy) drop_pend = 1'b1;
          else push_frame(h, yp, xb, yb);
        end
      end
    end
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_len"}, cap_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < cap_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, cap_q[i]}, {24'd0, exp6[i]});
  endtask

  initial begin
    int d0, h0, f3, ry, rx, rb;
    bit rh;
    rst = 1'b1; frame_tick = 1'b0; tx_ready = 1'b0; host = 1'b0;
    y_pad = 10'd0; x_ball = 11'd0; y_ball = 10'd0;
    tick3 = 1'b0; ready3 = 1'b1;

    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("rst_valid3", {31'd0, valid3}, 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);

    // nominal host frame
    cap_q.delete();
    step(1, 1, 0, 1, 300, 632, 350);
    repeat (10) step(0, 1, 0, 1, 300, 632, 350);
    exp6 = '{8'hA5, 8'h4B, 8'h13, 8'hC2, 8'hBD, 8'h27};
    check_cap("nominal");

    // guest frame
    cap_q.delete();
    step(1, 1, 0, 0, 300, 632, 350);
    repeat (10) step(0, 1, 0, 0, 300, 632, 350);
    exp6 = '{8'hA5, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h4B};
    check_cap("guest");

    // backpressure
    cap_q.delete();
    step(1, 1'($urandom_range(0, 1)), 0, 1, 777, 1500, 900);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || done_pend); i++)
      step(0, 1'($urandom_range(0, 1)), 0, 1, $urandom_range(0, 1023), $urandom_range(0, 2047), 5);
    chk("bp_handshakes", cap_q.size(), 32'd6);
    repeat (3) step(0, 1, 0, 1, 0, 0, 0);

    // drop while idx==2
    cap_q.delete();
    d0 = obs_drops;
    step(1, 1, 0, 1, 100, 200, 300);
    for (int i = 0; i < 20 && cap_q.size() < 2; i++) step(0, 1, 0, 1, 100, 200, 300);
    step(1, 1, 0, 1, 999, 999, 999);
    repeat (12) step(0, 1, 0, 1, 999, 999, 999);
    chk("drop_pulses", obs_drops - d0, 32'd1);
    chk("drop_one_frame", cap_q.size(), 32'd6);

    // randomized traffic, inputs change every cycle
    for (int i = 0; i < 600; i++) begin
      ry = $urandom_range(0, 1023); rx = $urandom_range(0, 2047);
      rb = $urandom_range(0, 1023); rh = 1'($urandom_range(0, 1));
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, 0, rh, ry, rx, rb);
    end
    repeat (30) step(0, 1, 0, 1, 0, 0, 0);

    // reset after the third handshake
    cap_q.delete();
    step(1, 1, 0, 1, 300, 632, 350);
    for (int i = 0; i < 20 && cap_q.size() < 3; i++) step(0, 1, 0, 1, 300, 632, 350);
    h0 = cap_q.size();
    chk("rst_mid_hs", h0, 32'd3);
    step(0, 1, 1, 1, 300, 632, 350);
    step(0, 1, 1, 1, 300, 632, 350);
    step(0, 1, 0, 1, 300, 632, 350);
    cap_q.delete();
    step(1, 1, 0, 1, 300, 632, 350);
    repeat (10) step(0, 1, 0, 1, 300, 632, 350);
    exp6 = '{8'hA5, 8'h4B, 8'h13, 8'hC2, 8'hBD, 8'h27};
    check_cap("after_rst");

    // divider by 3 on the second instance
    f3 = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); tick3 = 1'b1;
      @(negedge clk); tick3 = 1'b0;
      chk($sformatf("div_tick%0d", k), {31'd0, valid3}, {31'd0, (k == 3 || k == 6)});
      if (valid3 && data3 == 8'hA5) f3++;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        chk("div_drop", {31'd0, drop3}, 32'd0);
        if (valid3 && data3 == 8'hA5) f3++;
      end
    end
    chk("div_frames", f3, 32'd2);
    chk("div_idle", {31'd0, busy3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
